// File: rtl/inst_align_pkg.sv
// Shared front-end definitions: halfword width, RVC classification and the
// instruction bundle handed from the realigner to the decoder stage.
package inst_align_pkg;

    localparam int HW_W     = 16;
    localparam int INST_W   = 32;
    localparam int PC_W_MAX = 64;

    typedef struct packed {
        logic [INST_W-1:0]   inst;
        logic [PC_W_MAX-1:0] pc;
        logic                is16;
        logic                illegal16;
    } inst_bundle_t;

    // Any halfword whose low two bits are not 2'b11 starts a compressed instruction.
    function automatic logic is_rvc(input logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

    // Number of halfwords occupied by an instruction starting with this halfword.
    function automatic logic [1:0] inst_hw_len(input logic [HW_W-1:0] hw);
        return is_rvc(hw) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/inst_align_hq.sv
// Small halfword shift buffer: pops 0/1/2 halfwords from the head, then appends
// 0/1/2 halfwords at the resulting tail in the same cycle.
module inst_align_hq
    import inst_align_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [1:0]      pop_n,
    input  logic [1:0]      push_n,
    input  logic [HW_W-1:0] push_a,
    input  logic [HW_W-1:0] push_b,
    output logic [HW_W-1:0] hq0,
    output logic [HW_W-1:0] hq1,
    output logic [1:0]      cnt
);

    logic [HW_W-1:0] hq_q [DEPTH];
    logic [HW_W-1:0] hq_d [DEPTH];
    logic [1:0]      cnt_q;
    logic [1:0]      cnt_d;

    logic [HW_W-1:0] shifted [DEPTH];
    logic [1:0]      base;

    always_comb begin
        base = cnt_q - pop_n;
        for (int i = 0; i < DEPTH; i++) begin
            shifted[i] = '0;
            if (i + int'(pop_n) < DEPTH) begin
                shifted[i] = hq_q[2'(i + int'(pop_n))];
            end
        end

        // Push lands at the post-pop tail; the caller never overfills the buffer.
        hq_d = shifted;
        for (int i = 0; i < DEPTH; i++) begin
            if (push_n != 2'd0 && i == int'(base)) begin
                hq_d[i] = push_a;
            end
            if (push_n == 2'd2 && i == int'(base) + 1) begin
                hq_d[i] = push_b;
            end
        end
        cnt_d = base + push_n;

        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                hq_d[i] = '0;
            end
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hq_q[i] <= '0;
            end
            cnt_q <= 2'd0;
        end else begin
            hq_q  <= hq_d;
            cnt_q <= cnt_d;
        end
    end

    assign hq0 = hq_q[0];
    assign hq1 = hq_q[1];
    assign cnt = cnt_q;

endmodule

// File: rtl/inst_align.sv
// Instruction realigner: turns aligned 32-bit fetch words into a stream of
// complete 16/32-bit instructions with their PCs, honouring redirects.
module inst_align
    import inst_align_pkg::*;
#(
    parameter int PC_W     = 64,
    parameter int HQ_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [31:0]       fetch_data,
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic              flush_valid,
    input  logic [PC_W-1:0]   flush_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              inst_is16,
    output logic              inst_illegal16
);

    // Handshake: a transfer happens on a port in any cycle where both valid and
    // ready are high; valid never depends on ready, and flush suppresses both.

    logic [PC_W-1:0] head_pc_q, head_pc_d;
    logic            skip_lo_q, skip_lo_d;

    logic [HW_W-1:0] hq0, hq1;
    logic [1:0]      cnt;
    logic            h16;
    logic            do_push, do_pop;
    logic [1:0]      pop_n, push_n;
    logic [1:0]      cnt_after_pop;
    logic [HW_W-1:0] push_a, push_b;
    inst_bundle_t    bundle;
    logic            flush_pc_unused;

    assign flush_pc_unused = ^{flush_pc[PC_W-1:2], flush_pc[0]};

    assign h16        = is_rvc(hq0);
    assign inst_valid = ~flush_valid &
                        ((cnt >= 2'd1 & h16) | (cnt >= 2'd2 & ~h16));
    // Uses pre-pop occupancy so a same-cycle pop never feeds back into ready.
    assign fetch_ready = ~rst & ~flush_valid & (cnt <= 2'd1);

    assign do_push = fetch_valid & fetch_ready;
    assign do_pop  = inst_valid & inst_ready;

    always_comb begin
        pop_n  = do_pop ? inst_hw_len(hq0) : 2'd0;
        push_n = 2'd0;
        push_a = fetch_data[15:0];
        push_b = fetch_data[31:16];
        if (do_push) begin
            push_n = skip_lo_q ? 2'd1 : 2'd2;
            if (skip_lo_q) begin
                push_a = fetch_data[31:16];
            end
        end
        cnt_after_pop = cnt - pop_n;
    end

    always_comb begin
        head_pc_d = head_pc_q;
        skip_lo_d = skip_lo_q;
        if (flush_valid) begin
            skip_lo_d = flush_pc[1];
        end else begin
            if (do_pop) begin
                head_pc_d = head_pc_q + (h16 ? PC_W'(2) : PC_W'(4));
            end
            if (do_push) begin
                skip_lo_d = 1'b0;
                // An empty buffer takes its head address from the incoming word.
                if (cnt_after_pop == 2'd0) begin
                    head_pc_d = fetch_pc + (skip_lo_q ? PC_W'(2) : PC_W'(0));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_pc_q <= '0;
            skip_lo_q <= 1'b0;
        end else begin
            head_pc_q <= head_pc_d;
            skip_lo_q <= skip_lo_d;
        end
    end

    inst_align_hq #(
        .DEPTH (HQ_DEPTH)
    ) u_hq (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush_valid),
        .pop_n  (pop_n),
        .push_n (push_n),
        .push_a (push_a),
        .push_b (push_b),
        .hq0    (hq0),
        .hq1    (hq1),
        .cnt    (cnt)
    );

    // Flags are qualified with inst_valid so an empty buffer reads as all-zero.
    always_comb begin
        bundle.inst      = h16 ? {16'b0, hq0} : {hq1, hq0};
        bundle.pc        = PC_W_MAX'(head_pc_q);
        bundle.is16      = h16 & inst_valid;
        bundle.illegal16 = h16 & (hq0 == '0) & inst_valid;
    end

    assign inst           = bundle.inst;
    assign inst_pc        = bundle.pc[PC_W-1:0];
    assign inst_is16      = bundle.is16;
    assign inst_illegal16 = bundle.illegal16;

endmodule

// File: tb/tb_inst_align.sv
// Directed bench for inst_align: each step advances one clock and checks the
// outputs 1ns later against hand-computed values.
module tb_inst_align;

    localparam int PC_W = 64;

    logic            clk;
    logic            rst;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [31:0]     fetch_data;
    logic [PC_W-1:0] fetch_pc;
    logic            flush_valid;
    logic [PC_W-1:0] flush_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [PC_W-1:0] inst_pc;
    logic            inst_is16;
    logic            inst_illegal16;

    int tests_run    = 0;
    int tests_failed = 0;

    inst_align #(
        .PC_W     (PC_W),
        .HQ_DEPTH (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_data     (fetch_data),
        .fetch_pc       (fetch_pc),
        .flush_valid    (flush_valid),
        .flush_pc       (flush_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_is16      (inst_is16),
        .inst_illegal16 (inst_illegal16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] e_inst,
                            input logic [63:0] e_pc, input logic e_is16);
        chk({tag, "_valid"}, 64'(inst_valid), 64'd1);
        chk({tag, "_inst"},  64'(inst), 64'(e_inst));
        chk({tag, "_pc"},    inst_pc, e_pc);
        chk({tag, "_is16"},  64'(inst_is16), 64'(e_is16));
    endtask

    task automatic fetch(input logic [31:0] data, input logic [63:0] pc);
        fetch_valid = 1'b1;
        fetch_data  = data;
        fetch_pc    = pc;
    endtask

    initial begin
        rst         = 1'b1;
        fetch_valid = 1'b0;
        fetch_data  = '0;
        fetch_pc    = '0;
        flush_valid = 1'b0;
        flush_pc    = '0;
        inst_ready  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_valid",   64'(inst_valid), 64'd0);
        chk("rst_inst",    64'(inst), 64'd0);
        chk("rst_pc",      inst_pc, 64'd0);
        chk("rst_is16",    64'(inst_is16), 64'd0);
        chk("rst_ill",     64'(inst_illegal16), 64'd0);
        chk("rst_fready",  64'(fetch_ready), 64'd0);

        // Two RVC in one word
        rst        = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("t1_fready", 64'(fetch_ready), 64'd1);
        fetch(32'h4585_4501, 64'h8000_0000);
        step();
        fetch_valid = 1'b0;
        chk_inst("t1_a", 32'h0000_4501, 64'h8000_0000, 1'b1);
        chk("t1_a_ill", 64'(inst_illegal16), 64'd0);
        step();
        chk_inst("t1_b", 32'h0000_4585, 64'h8000_0002, 1'b1);
        step();
        chk("t1_empty", 64'(inst_valid), 64'd0);

        // Aligned 32-bit
        fetch(32'h0000_0513, 64'h8000_0000);
        step();
        fetch_valid = 1'b0;
        chk_inst("t2", 32'h0000_0513, 64'h8000_0000, 1'b0);
        step();
        chk("t2_empty", 64'(inst_valid), 64'd0);

        // Straddle across two words
        fetch(32'h0513_4501, 64'h8000_0000);
        step();
        fetch(32'h4585_0000, 64'h8000_0004);
        chk_inst("t3_a", 32'h0000_4501, 64'h8000_0000, 1'b1);
        chk("t3_fready_full", 64'(fetch_ready), 64'd0);
        step();
        chk("t3_wait", 64'(inst_valid), 64'd0);
        chk("t3_fready", 64'(fetch_ready), 64'd1);
        step();
        fetch_valid = 1'b0;
        chk_inst("t3_b", 32'h0000_0513, 64'h8000_0002, 1'b0);
        step();
        chk_inst("t3_c", 32'h0000_4585, 64'h8000_0006, 1'b1);
        step();
        chk("t3_empty", 64'(inst_valid), 64'd0);

        // Odd-halfword redirect
        flush_valid = 1'b1;
        flush_pc    = 64'h8000_0102;
        #1;
        chk("t4_fl_valid",  64'(inst_valid), 64'd0);
        chk("t4_fl_fready", 64'(fetch_ready), 64'd0);
        step();
        flush_valid = 1'b0;
        fetch(32'h4585_4501, 64'h8000_0100);
        step();
        fetch_valid = 1'b0;
        chk_inst("t4", 32'h0000_4585, 64'h8000_0102, 1'b1);
        step();
        chk("t4_empty", 64'(inst_valid), 64'd0);

        // Backpressure on the instruction side
        inst_ready = 1'b0;
        fetch(32'h0513_4501, 64'h8000_0200);
        step();
        fetch(32'h4585_0000, 64'h8000_0204);
        chk_inst("t5_a", 32'h0000_4501, 64'h8000_0200, 1'b1);
        chk("t5_a_fready", 64'(fetch_ready), 64'd0);
        step();
        chk_inst("t5_a_hold", 32'h0000_4501, 64'h8000_0200, 1'b1);
        chk("t5_a_hold_fready", 64'(fetch_ready), 64'd0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("t5_wait", 64'(inst_valid), 64'd0);
        chk("t5_wait_fready", 64'(fetch_ready), 64'd1);
        step();
        fetch_valid = 1'b0;
        chk_inst("t5_b", 32'h0000_0513, 64'h8000_0202, 1'b0);
        chk("t5_b_fready", 64'(fetch_ready), 64'd0);
        step();
        chk_inst("t5_b_hold", 32'h0000_0513, 64'h8000_0202, 1'b0);
        inst_ready = 1'b1;
        step();
        chk_inst("t5_c", 32'h0000_4585, 64'h8000_0206, 1'b1);
        step();
        chk("t5_empty", 64'(inst_valid), 64'd0);

        // Flush with half a 32-bit instruction buffered, then illegal 16-bit zeros
        fetch(32'h0513_4501, 64'h8000_0300);
        step();
        fetch_valid = 1'b0;
        chk_inst("t6_a", 32'h0000_4501, 64'h8000_0300, 1'b1);
        step();
        chk("t6_partial", 64'(inst_valid), 64'd0);
        flush_valid = 1'b1;
        flush_pc    = 64'h8000_0400;
        #1;
        chk("t6_fl_valid",  64'(inst_valid), 64'd0);
        chk("t6_fl_fready", 64'(fetch_ready), 64'd0);
        step();
        flush_valid = 1'b0;
        chk("t6_after_valid", 64'(inst_valid), 64'd0);
        fetch(32'h0000_0000, 64'h8000_0400);
        step();
        fetch_valid = 1'b0;
        chk_inst("t6_b", 32'h0000_0000, 64'h8000_0400, 1'b1);
        chk("t6_b_ill", 64'(inst_illegal16), 64'd1);
        step();
        chk_inst("t6_c", 32'h0000_0000, 64'h8000_0402, 1'b1);
        chk("t6_c_ill", 64'(inst_illegal16), 64'd1);
        step();
        chk("t6_empty", 64'(inst_valid), 64'd0);
        chk("t6_empty_ill", 64'(inst_illegal16), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
